// File: rtl/line_buf_ctrl.sv
// line_buf_ctrl: sequences the read and write ports of two external fifo_ram
// line buffers. Each accepted raster pixel comes out one cycle later as a
// vertical column (y-2, y-1, y), which feeds the downstream 3x3 window stage.
// FIFO0 holds the previous row and FIFO1 holds the row before that.
//
// state    | meaning
// ---------+----------------------------------------------------------------
// S_FLUSH  | dummy reads/writes walk every FIFO pointer back to address 0
// S_IDLE   | waiting for a pixel tagged sof; untagged pixels are dropped
// S_ACTIVE | inside a frame; x_cnt/y_cnt give the position of the next pixel
module line_buf_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 1920,
    parameter int IMG_HEIGHT = 1080,
    localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1,
    localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sof,
    input  logic                  pix_valid,
    input  logic [DATA_WIDTH-1:0] pix_data,
    output logic                  pix_ready,
    output logic                  f0_wr_en,
    output logic [DATA_WIDTH-1:0] f0_wr_data,
    output logic                  f0_rd_en,
    input  logic [DATA_WIDTH-1:0] f0_rd_data,
    output logic                  f1_wr_en,
    output logic [DATA_WIDTH-1:0] f1_wr_data,
    output logic                  f1_rd_en,
    input  logic [DATA_WIDTH-1:0] f1_rd_data,
    output logic                  win_valid,
    output logic [DATA_WIDTH-1:0] win_top,
    output logic [DATA_WIDTH-1:0] win_mid,
    output logic [DATA_WIDTH-1:0] win_bot,
    output logic [XW-1:0]         win_x,
    output logic [YW-1:0]         win_y,
    output logic                  frame_err
);

    typedef enum logic [1:0] {
        S_FLUSH  = 2'd0,
        S_IDLE   = 2'd1,
        S_ACTIVE = 2'd2
    } state_t;

    localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

    state_t state, state_nxt;

    logic [XW-1:0]         x_cnt, pix_x;
    logic [YW-1:0]         y_cnt, pix_y;
    logic                  take;
    logic                  flush;
    logic                  ptrs_home;
    logic                  col_pend;
    logic                  f1_pend;
    logic [DATA_WIDTH-1:0] mid_hold;
    logic [DATA_WIDTH-1:0] top_hold;

    // Shadow copies of the fifo_ram pointers. They only carry a power-up value:
    // the RAM pointers are not reset, so rst must not disturb the copies either.
    logic [XW-1:0] wr0_ptr = '0;
    logic [XW-1:0] rd0_ptr = '0;
    logic [XW-1:0] wr1_ptr = '0;
    logic [XW-1:0] rd1_ptr = '0;

    function automatic logic [XW-1:0] ptr_inc(input logic [XW-1:0] p);
        return (p == X_LAST) ? '0 : p + XW'(1);
    endfunction

    assign ptrs_home = (wr0_ptr == '0) && (rd0_ptr == '0) &&
                       (wr1_ptr == '0) && (rd1_ptr == '0) && !f1_pend;

    // Next-state, handshake and abort decode
    always_comb begin
        state_nxt = state;
        pix_ready = 1'b0;
        take      = 1'b0;
        frame_err = 1'b0;
        pix_x     = x_cnt;
        pix_y     = y_cnt;
        if (!rst) begin
            unique case (state)
                S_FLUSH: begin
                    if (ptrs_home) state_nxt = S_IDLE;
                end
                S_IDLE: begin
                    pix_ready = 1'b1;
                    pix_x     = '0;
                    pix_y     = '0;
                    if (pix_valid && sof) begin
                        take      = 1'b1;
                        state_nxt = S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    pix_ready = 1'b1;
                    if (pix_valid && sof) begin
                        frame_err = 1'b1;
                        state_nxt = S_FLUSH;
                    end else if (pix_valid) begin
                        take = 1'b1;
                        if (pix_x == X_LAST && pix_y == Y_LAST) state_nxt = S_IDLE;
                    end
                end
                default: state_nxt = S_FLUSH;
            endcase
        end
    end

    // FIFO port drive: live pixel traffic, the delayed FIFO1 refill, or flush dummies
    assign flush      = (state == S_FLUSH) && !rst;
    assign f0_wr_en   = take | (flush & (wr0_ptr != '0));
    assign f0_wr_data = take ? pix_data : '0;
    assign f0_rd_en   = (take & (pix_y != '0)) | (flush & (rd0_ptr != '0));
    assign f1_rd_en   = (take & (pix_y > YW'(1))) | (flush & (rd1_ptr != '0));
    assign f1_wr_en   = (f1_pend & !rst) | (flush & (wr1_ptr != '0));
    assign f1_wr_data = f1_pend ? f0_rd_data : '0;

    // Upper rows arrive from the RAMs in the output cycle; hold them across gaps
    assign win_mid = col_pend ? f0_rd_data : mid_hold;
    assign win_top = col_pend ? f1_rd_data : top_hold;

    // State register and raster position
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FLUSH;
            x_cnt <= '0;
            y_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (take) begin
                if (pix_x == X_LAST) begin
                    x_cnt <= '0;
                    y_cnt <= (pix_y == Y_LAST) ? '0 : pix_y + YW'(1);
                end else begin
                    x_cnt <= pix_x + XW'(1);
                    y_cnt <= pix_y;
                end
            end
        end
    end

    // One-cycle output column pipeline and the pending FIFO1 write
    always_ff @(posedge clk) begin
        if (rst) begin
            col_pend  <= 1'b0;
            f1_pend   <= 1'b0;
            win_valid <= 1'b0;
            win_bot   <= '0;
            win_x     <= '0;
            win_y     <= '0;
            mid_hold  <= '0;
            top_hold  <= '0;
        end else begin
            col_pend  <= take;
            f1_pend   <= take && (pix_y != '0);
            win_valid <= take && (pix_y > YW'(1));
            if (col_pend) begin
                mid_hold <= f0_rd_data;
                top_hold <= f1_rd_data;
            end
            if (take) begin
                win_bot <= pix_data;
                win_x   <= pix_x;
                win_y   <= pix_y;
            end
        end
    end

    // Shadow pointers follow every enable actually issued to the RAMs
    always_ff @(posedge clk) begin
        if (f0_wr_en) wr0_ptr <= ptr_inc(wr0_ptr);
        if (f0_rd_en) rd0_ptr <= ptr_inc(rd0_ptr);
        if (f1_wr_en) wr1_ptr <= ptr_inc(wr1_ptr);
        if (f1_rd_en) rd1_ptr <= ptr_inc(rd1_ptr);
    end

endmodule

// File: tb/tb_line_buf_ctrl.sv
// Bench for line_buf_ctrl on a 4x3 image. Two behavioural fifo_ram models
// (read-before-write, 1-cycle read latency, free-running pointers) close the
// loop; expected columns come from a plain image array indexed by (x, y).
module tb_line_buf_ctrl;

    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int XW = 2;
    localparam int YW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          sof;
    logic          pix_valid;
    logic [DW-1:0] pix_data;
    logic          pix_ready;
    logic          f0_wr_en, f0_rd_en, f1_wr_en, f1_rd_en;
    logic [DW-1:0] f0_wr_data, f0_rd_data, f1_wr_data, f1_rd_data;
    logic          win_valid;
    logic [DW-1:0] win_top, win_mid, win_bot;
    logic [XW-1:0] win_x;
    logic [YW-1:0] win_y;
    logic          frame_err;

    always #5 clk = ~clk;

    line_buf_ctrl #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .rst(rst), .sof(sof), .pix_valid(pix_valid), .pix_data(pix_data),
        .pix_ready(pix_ready),
        .f0_wr_en(f0_wr_en), .f0_wr_data(f0_wr_data), .f0_rd_en(f0_rd_en), .f0_rd_data(f0_rd_data),
        .f1_wr_en(f1_wr_en), .f1_wr_data(f1_wr_data), .f1_rd_en(f1_rd_en), .f1_rd_data(f1_rd_data),
        .win_valid(win_valid), .win_top(win_top), .win_mid(win_mid), .win_bot(win_bot),
        .win_x(win_x), .win_y(win_y), .frame_err(frame_err)
    );

    // fifo_ram models: pointers are never reset, reads see the old word
    logic [DW-1:0] mem0 [0:W-1];
    logic [DW-1:0] mem1 [0:W-1];
    int wp0 = 0, rp0 = 0, wp1 = 0, rp1 = 0;

    always @(posedge clk) begin
        if (f0_rd_en) begin f0_rd_data <= mem0[rp0]; rp0 <= (rp0 + 1) % W; end
        if (f0_wr_en) begin mem0[wp0] <= f0_wr_data; wp0 <= (wp0 + 1) % W; end
        if (f1_rd_en) begin f1_rd_data <= mem1[rp1]; rp1 <= (rp1 + 1) % W; end
        if (f1_wr_en) begin mem1[wp1] <= f1_wr_data; wp1 <= (wp1 + 1) % W; end
    end

    // Reference: pixels of the frame in flight, plus the bench's view of the raster
    logic [DW-1:0] img [0:H-1][0:W-1];
    bit  in_frame  = 0;
    bit  exp_ready = 0;
    bit  last_ready;
    int  cx, cy;
    bit  pend = 0;
    int  pend_x, pend_y;
    int  n_vec = 0, n_err = 0;
    int  f0_wr_cnt = 0, f1_wr_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One clock: drive inputs, check at negedge, return just after the next posedge
    task automatic step(input bit v, input bit s, input logic [DW-1:0] d);
        bit pend_prev;
        bit acc;
        pix_valid = v;
        sof       = s;
        pix_data  = d;
        @(negedge clk);
        pend_prev  = pend;
        last_ready = pix_ready;
        if (f0_wr_en) f0_wr_cnt++;
        if (f1_wr_en) f1_wr_cnt++;
        if (pend) begin
            chk("win_valid", 32'(win_valid), 32'(pend_y >= 2));
            chk("win_bot",   32'(win_bot),   32'(img[pend_y][pend_x]));
            chk("win_x",     32'(win_x),     32'(pend_x));
            chk("win_y",     32'(win_y),     32'(pend_y));
            if (pend_y >= 1) begin
                chk("f0_rd_data", 32'(f0_rd_data), 32'(img[pend_y-1][pend_x]));
                chk("win_mid",    32'(win_mid),    32'(img[pend_y-1][pend_x]));
                chk("f1_wr_en",   32'(f1_wr_en),   32'd1);
                chk("f1_wr_data", 32'(f1_wr_data), 32'(img[pend_y-1][pend_x]));
            end
            if (pend_y >= 2) chk("win_top", 32'(win_top), 32'(img[pend_y-2][pend_x]));
        end else begin
            chk("win_valid_gap", 32'(win_valid), 32'd0);
        end
        pend = 0;
        chk("frame_err", 32'(frame_err), 32'(v && s && in_frame));
        if (v && exp_ready) chk("pix_ready", 32'(pix_ready), 32'd1);
        if (!v && exp_ready) begin
            chk("gap_f0_wr_en", 32'(f0_wr_en), 32'd0);
            chk("gap_f0_rd_en", 32'(f0_rd_en), 32'd0);
            chk("gap_f1_rd_en", 32'(f1_rd_en), 32'd0);
        end
        if (!pend_prev && exp_ready) chk("idle_f1_wr_en", 32'(f1_wr_en), 32'd0);
        acc = v && pix_ready;
        if (acc) begin
            if (in_frame && s) begin
                chk("abort_f0_wr_en", 32'(f0_wr_en), 32'd0);
                in_frame  = 0;
                exp_ready = 0;
            end else if (in_frame || s) begin
                if (!in_frame) begin
                    cx = 0; cy = 0; in_frame = 1;
                end
                img[cy][cx] = d;
                chk("f0_wr_en",   32'(f0_wr_en),   32'd1);
                chk("f0_wr_data", 32'(f0_wr_data), 32'(d));
                chk("f0_rd_en",   32'(f0_rd_en),   32'(cy >= 1));
                chk("f1_rd_en",   32'(f1_rd_en),   32'(cy >= 2));
                pend = 1; pend_x = cx; pend_y = cy;
                if (cx == W - 1) begin
                    cx = 0;
                    if (cy == H - 1) in_frame = 0;
                    else cy++;
                end else begin
                    cx++;
                end
            end else begin
                chk("drop_f0_wr_en", 32'(f0_wr_en), 32'd0);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        bit ok = 0;
        for (int i = 0; i < 64 && !ok; i++) begin
            step(1'b0, 1'b0, '0);
            ok = last_ready;
        end
        chk({tag, "_ready_timeout"}, 32'(ok), 32'd1);
        exp_ready = ok;
        chk({tag, "_ptr_wr0"}, wp0, 0);
        chk({tag, "_ptr_rd0"}, rp0, 0);
        chk({tag, "_ptr_wr1"}, wp1, 0);
        chk({tag, "_ptr_rd1"}, rp1, 0);
    endtask

    task automatic do_reset(input bit first);
        rst = 1'b1; pix_valid = 1'b1; sof = 1'b0; pix_data = 8'hEE;
        @(negedge clk);
        chk("rst_f0_wr_en",  32'(f0_wr_en),  32'd0);
        chk("rst_f1_wr_en",  32'(f1_wr_en),  32'd0);
        chk("rst_pix_ready", 32'(pix_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0; pix_valid = 1'b0;
        pend = 0; in_frame = 0; exp_ready = 0;
        @(negedge clk);
        chk("rv_pix_ready", 32'(pix_ready), 32'd0);
        chk("rv_win_valid", 32'(win_valid), 32'd0);
        chk("rv_frame_err", 32'(frame_err), 32'd0);
        chk("rv_win_bot",   32'(win_bot),   32'd0);
        chk("rv_win_mid",   32'(win_mid),   32'd0);
        chk("rv_win_top",   32'(win_top),   32'd0);
        chk("rv_win_x",     32'(win_x),     32'd0);
        chk("rv_win_y",     32'(win_y),     32'd0);
        if (first) begin
            chk("rv_f0_wr_en", 32'(f0_wr_en), 32'd0);
            chk("rv_f0_rd_en", 32'(f0_rd_en), 32'd0);
            chk("rv_f1_wr_en", 32'(f1_wr_en), 32'd0);
            chk("rv_f1_rd_en", 32'(f1_rd_en), 32'd0);
        end
        if (f0_wr_en) f0_wr_cnt++;
        if (f1_wr_en) f1_wr_cnt++;
        @(posedge clk);
        #1;
        wait_ready("rst");
    endtask

    // kind: 0 = 16*y+x, 1 = 0x80+16*y+x, 2 = random; gap: 0 none, 1 one cycle, 2 random
    task automatic send_frame(input int kind, input int gap, input int npix);
        int n = 0;
        logic [DW-1:0] d;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                if (n == npix) return;
                if (kind == 0)      d = 8'(16 * y + x);
                else if (kind == 1) d = 8'(8'h80 + 16 * y + x);
                else                d = 8'($urandom);
                step(1'b1, (x == 0 && y == 0), d);
                n++;
                if (gap == 1) step(1'b0, 1'b0, '0);
                else if (gap == 2) repeat ($urandom_range(0, 2)) step(1'b0, 1'b0, '0);
            end
        end
    endtask

    initial begin
        int c0, c1;
        for (int i = 0; i < W; i++) begin
            mem0[i] = '0;
            mem1[i] = '0;
        end
        f0_rd_data = '0;
        f1_rd_data = '0;
        rst = 1'b1; sof = 1'b0; pix_valid = 1'b0; pix_data = '0;

        do_reset(1'b1);

        // untagged pixel in IDLE is dropped
        step(1'b1, 1'b0, 8'h3C);
        step(1'b0, 1'b0, '0);

        // directed 4x3 frame, then with a gap after every pixel
        send_frame(0, 0, -1);
        step(1'b0, 1'b0, '0);
        send_frame(0, 1, -1);
        step(1'b0, 1'b0, '0);

        // back-to-back frames
        send_frame(0, 0, -1);
        send_frame(1, 0, -1);
        step(1'b0, 1'b0, '0);

        // abort with sof at (2,1)
        send_frame(0, 0, 6);
        c0 = f0_wr_cnt;
        c1 = f1_wr_cnt;
        step(1'b1, 1'b1, 8'h55);
        wait_ready("abort");
        chk("abort_f0_writes", f0_wr_cnt - c0, 2);
        chk("abort_f1_writes", f1_wr_cnt - c1, 3);
        send_frame(0, 0, -1);
        step(1'b0, 1'b0, '0);

        // rst while pixel (1,2) is presented
        send_frame(2, 0, 9);
        do_reset(1'b0);
        send_frame(1, 0, -1);
        step(1'b0, 1'b0, '0);

        // random data with random gaps
        for (int i = 0; i < 6; i++) begin
            send_frame(2, 2, -1);
            repeat ($urandom_range(0, 3)) step(1'b0, 1'b0, '0);
        end
        step(1'b0, 1'b0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
